// File: rtl/rtc_pkg.sv
// rtc_pkg: shared constants, types and helpers for the RTC multiplexed-bus controller.
//   Field indices (F_ANO..F_ST), RTC register addresses, transfer command codes,
//   bus FSM state enum and the per-access payload struct.
package rtc_pkg;

    localparam int unsigned N_FIELDS = 9;
    localparam int unsigned FIELD_W  = 8;
    localparam int unsigned BUS_W    = N_FIELDS * FIELD_W;
    localparam int unsigned IDX_W    = 4;

    localparam int unsigned F_ANO      = 0;
    localparam int unsigned F_MES      = 1;
    localparam int unsigned F_DIA      = 2;
    localparam int unsigned F_HORAS    = 3;
    localparam int unsigned F_MINUTOS  = 4;
    localparam int unsigned F_SEGUNDOS = 5;
    localparam int unsigned F_HT       = 6;
    localparam int unsigned F_MT       = 7;
    localparam int unsigned F_ST       = 8;

    localparam logic [FIELD_W-1:0] ADDR_ANO      = 8'h26;
    localparam logic [FIELD_W-1:0] ADDR_MES      = 8'h25;
    localparam logic [FIELD_W-1:0] ADDR_DIA      = 8'h24;
    localparam logic [FIELD_W-1:0] ADDR_HORAS    = 8'h23;
    localparam logic [FIELD_W-1:0] ADDR_MINUTOS  = 8'h22;
    localparam logic [FIELD_W-1:0] ADDR_SEGUNDOS = 8'h21;
    localparam logic [FIELD_W-1:0] ADDR_HT       = 8'h43;
    localparam logic [FIELD_W-1:0] ADDR_MT       = 8'h42;
    localparam logic [FIELD_W-1:0] ADDR_ST       = 8'h41;
    localparam logic [FIELD_W-1:0] CMD_XFER_RD   = 8'hF0;
    localparam logic [FIELD_W-1:0] CMD_XFER_WR   = 8'hF1;

    typedef enum logic [2:0] {IDLE, ADR, ADR_GAP, DAT, DAT_GAP, FIN} state_t;

    // One bus access: direction, address, write data and destination field.
    typedef struct packed {
        logic               is_wr;
        logic [FIELD_W-1:0] addr;
        logic [FIELD_W-1:0] data;
        logic [IDX_W-1:0]   field;
    } access_t;

    function automatic logic [FIELD_W-1:0] field_addr(input logic [IDX_W-1:0] idx);
        logic [FIELD_W-1:0] a;
        case (idx)
            IDX_W'(F_ANO):      a = ADDR_ANO;
            IDX_W'(F_MES):      a = ADDR_MES;
            IDX_W'(F_DIA):      a = ADDR_DIA;
            IDX_W'(F_HORAS):    a = ADDR_HORAS;
            IDX_W'(F_MINUTOS):  a = ADDR_MINUTOS;
            IDX_W'(F_SEGUNDOS): a = ADDR_SEGUNDOS;
            IDX_W'(F_HT):       a = ADDR_HT;
            IDX_W'(F_MT):       a = ADDR_MT;
            IDX_W'(F_ST):       a = ADDR_ST;
            default:            a = '0;
        endcase
        return a;
    endfunction

    // Index of the lowest set bit; 0 when the mask is empty (caller checks).
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_FIELDS-1:0] m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = int'(N_FIELDS) - 1; i >= 0; i--) begin
            if (m[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [FIELD_W-1:0] get_field(input logic [BUS_W-1:0] d,
                                                     input logic [IDX_W-1:0] idx);
        logic [FIELD_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(N_FIELDS); i++) begin
            if (idx == IDX_W'(i)) r = d[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer: bus phase down-counter.
//   clk, reset : clock, synchronous active-high reset
//   load       : restart the phase (counter := PH_CYC-1)
//   last_c     : high on the final clock of the current phase
module rtc_phase_timer #(
    parameter int unsigned PH_CYC = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic last_c
);
    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] cnt;

    // Count down to zero and hold there until the next load.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(PH_CYC - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign last_c = (cnt == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: drives the RTC multiplexed address/data bus.
//   Requests : start_wr (write fields flagged in habilita), start_rd (read all nine)
//   Data     : wr_data / rd_data, field i at [8i+7:8i]
//   Status   : busy, done (one-cycle pulse at end of request)
//   Bus      : ad_out, ad_oe, ad_in, cs_n, rd_n, wr_n, a_d (all outputs registered)
// Optional build macro RTC_XFER_CMD_EN: reads are preceded by a 0xF0 latch command,
// non-empty writes are followed by a 0xF1 commit command.
module rtc_bus_ctrl
    import rtc_pkg::*;
#(
    parameter int unsigned PH_CYC = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_wr,
    input  logic                start_rd,
    input  logic [N_FIELDS-1:0] habilita,
    input  logic [BUS_W-1:0]    wr_data,
    output logic [BUS_W-1:0]    rd_data,
    output logic                busy,
    output logic                done,
    output logic [FIELD_W-1:0]  ad_out,
    output logic                ad_oe,
    input  logic [FIELD_W-1:0]  ad_in,
    output logic                cs_n,
    output logic                rd_n,
    output logic                wr_n,
    output logic                a_d
);
`ifdef RTC_XFER_CMD_EN
    localparam bit CMD_EN = 1'b1;
`else
    localparam bit CMD_EN = 1'b0;
`endif

    state_t              state;
    access_t             acc;
    logic [N_FIELDS-1:0] pend;
    logic                post_q;
    logic                txn_wr;

    logic                last_c, load_c, req_c, launch_c, phase_c;
    logic                sel_wr, sel_pre, sel_post, nxt_valid, nxt_post;
    logic [N_FIELDS-1:0] sel_mask, nxt_mask;
    access_t             nxt_acc;

    rtc_phase_timer #(.PH_CYC(PH_CYC)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (load_c),
        .last_c (last_c)
    );

    // Pick the next access: latch command, then pending fields low-to-high, then commit.
    always_comb begin
        sel_wr   = txn_wr;
        sel_mask = pend;
        sel_pre  = 1'b0;
        sel_post = post_q;
        if (state == IDLE) begin
            sel_wr   = start_wr;
            sel_mask = start_wr ? habilita : {N_FIELDS{1'b1}};
            sel_pre  = CMD_EN && !start_wr;
            sel_post = CMD_EN && start_wr && (habilita != '0);
        end
        nxt_valid     = 1'b1;
        nxt_mask      = sel_mask;
        nxt_post      = sel_post;
        nxt_acc.field = lowest_set(sel_mask);
        nxt_acc.is_wr = sel_wr;
        nxt_acc.addr  = field_addr(nxt_acc.field);
        nxt_acc.data  = get_field(wr_data, nxt_acc.field);
        if (sel_pre) begin
            nxt_acc.is_wr = 1'b1;
            nxt_acc.addr  = CMD_XFER_RD;
            nxt_acc.data  = CMD_XFER_RD;
        end else if (sel_mask != '0) begin
            nxt_mask = sel_mask & ~(N_FIELDS'(1) << nxt_acc.field);
        end else if (sel_post) begin
            nxt_acc.is_wr = 1'b1;
            nxt_acc.addr  = CMD_XFER_WR;
            nxt_acc.data  = CMD_XFER_WR;
            nxt_post      = 1'b0;
        end else begin
            nxt_valid = 1'b0;
        end
    end

    assign req_c    = start_wr || start_rd;
    assign phase_c  = (state == ADR) || (state == ADR_GAP) || (state == DAT) || (state == DAT_GAP);
    assign launch_c = nxt_valid && (((state == IDLE) && req_c) || ((state == DAT_GAP) && last_c));
    assign load_c   = ((state == IDLE) && req_c) || (phase_c && last_c);

    // Bus FSM with registered strobes; launch block overrides the case when an access starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= '0;
            pend    <= '0;
            post_q  <= 1'b0;
            txn_wr  <= 1'b0;
            rd_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ad_out  <= '0;
            ad_oe   <= 1'b0;
            cs_n    <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            a_d     <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_c && !nxt_valid) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                ADR: begin
                    if (last_c) begin
                        state <= ADR_GAP;
                        cs_n  <= 1'b1;
                        wr_n  <= 1'b1;
                    end
                end
                ADR_GAP: begin
                    if (last_c) begin
                        state <= DAT;
                        cs_n  <= 1'b0;
                        a_d   <= 1'b1;
                        if (acc.is_wr) begin
                            wr_n   <= 1'b0;
                            ad_oe  <= 1'b1;
                            ad_out <= acc.data;
                        end else begin
                            rd_n  <= 1'b0;
                            ad_oe <= 1'b0;
                        end
                    end
                end
                DAT: begin
                    if (last_c) begin
                        state <= DAT_GAP;
                        cs_n  <= 1'b1;
                        rd_n  <= 1'b1;
                        wr_n  <= 1'b1;
                        // Read data is sampled on the final clock of the data phase.
                        if (!acc.is_wr) begin
                            for (int i = 0; i < int'(N_FIELDS); i++) begin
                                if (acc.field == IDX_W'(i)) rd_data[8*i +: 8] <= ad_in;
                            end
                        end
                    end
                end
                DAT_GAP: begin
                    if (last_c && !nxt_valid) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        ad_oe <= 1'b0;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase

            if (launch_c) begin
                state  <= ADR;
                busy   <= 1'b1;
                cs_n   <= 1'b0;
                wr_n   <= 1'b0;
                rd_n   <= 1'b1;
                a_d    <= 1'b0;
                ad_oe  <= 1'b1;
                ad_out <= nxt_acc.addr;
                acc    <= nxt_acc;
                pend   <= nxt_mask;
                post_q <= nxt_post;
                txn_wr <= sel_wr;
            end
        end
    end

endmodule
